arp_request: RTL and testbench
==============================

# arp_request

Initiator side of ARP: on a START pulse it transmits a broadcast Ethernet/IPv4 ARP request for TARGET_IPV4, then monitors the receive byte stream for the matching ARP reply and returns the sender's MAC. It connects to the same byte-wide MAC interface as arp_response. Both RX and TX run on a single clock. Timeout and retry are built in; the result is reported as a DONE or FAIL pulse.

## Interface
- TIMEOUT_CYCLES, 1000: cycles spent in WAIT per attempt before retrying (1..2^24-1).
- MAX_TRIES, 3: total request transmissions before FAIL (1..15).
- CLK  in  1: single clock for RX and TX paths.
- ARESET  in  1: asynchronous, active-high reset.
- MY_MAC  in  48: own MAC; quasi-static, stable while BUSY.
- MY_IPV4  in  32: own IPv4 address; quasi-static.
- START  in  1: one-cycle request strobe; accepted only in IDLE.
- TARGET_IPV4  in  32: IPv4 address to resolve; latched when START is accepted.
- DATA_VALID_RX  in  1: high for the contiguous bytes of one received frame.
- DATA_RX  in  8: received byte; valid when DATA_VALID_RX is high.
- DATA_ACK_TX  in  1: MAC has consumed the current DATA_TX byte.
- DATA_VALID_TX  out  1: TX frame in progress.
- DATA_TX  out  8: TX byte.
- BUSY  out  1: high in every state except IDLE.
- DONE  out  1: one-cycle pulse when the address is resolved.
- FAIL  out  1: one-cycle pulse when all tries have timed out.
- RESOLVED_MAC  out  48: SHA from the matching reply; holds its value until the next DONE.

## Operation
- States: IDLE, TX, WAIT.
  - IDLE -> TX on START.
  - TX -> WAIT after byte 41 is acked.
  - WAIT -> IDLE on a matched reply (DONE).
  - WAIT -> TX on timeout when tries < MAX_TRIES.
  - WAIT -> IDLE on timeout when tries == MAX_TRIES (FAIL).
- TX frame is 42 bytes, no padding, MSB byte first:
  - dest FF×6
  - src MY_MAC
  - 08 06
  - 00 01
  - 08 00
  - 06, 04
  - 00 01
  - SHA MY_MAC
  - SPA MY_IPV4
  - THA 00×6
  - TPA latched target.
- TX handshake:
  - DATA_VALID_TX rises with byte 0 and stays high until byte 41 is acked.
  - DATA_TX is held until DATA_ACK_TX is sampled high, then advances on the next cycle.
  - DATA_ACK_TX is ignored while DATA_VALID_TX is low.
- RX parser:
  - A byte counter (saturating at 63) advances on each valid byte.
  - Field checks are accumulated into a match flag.
  - Required fields:
    - dest == MY_MAC
    - type 0806
    - HRD 0001
    - PRO 0800
    - HLN 06
    - PLN 04
    - OP 0002
    - SPA == latched target
    - TPA == MY_IPV4.
  - SHA (bytes 22–27) is captured into a shadow register.
  - Bytes 42 and later (padding, FCS) are ignored.
  - The frame is evaluated when DATA_VALID_RX is sampled low. It counts as a match only if the flag is set and byte count ≥ 42.
- Only frames whose first byte arrives in WAIT are eligible. Frames already in progress when WAIT is entered are discarded whole.
- A non-matching frame (ARP request, wrong IP, runt) has no effect; WAIT continues.
- START while BUSY is ignored. TARGET_IPV4 is not re-latched on retries.

## Timing
- Reset values: DATA_VALID_TX=0, DATA_TX=00, BUSY=0, DONE=0, FAIL=0, RESOLVED_MAC=0, state IDLE, try count 0.
- ARESET mid-frame: DATA_VALID_TX drops asynchronously and the frame is truncated. No DONE or FAIL is issued.
- START sampled at edge N → BUSY=1 and DATA_VALID_TX=1 with DATA_TX=FF after edge N.
- With ACK tied high, the frame occupies exactly 42 cycles.
- Timeout counter:
  - Cleared on entry to WAIT and increments every WAIT cycle.
  - Timeout fires when the count reaches TIMEOUT_CYCLES-1.
  - The retry frame's byte 0 appears on the following cycle.
- Match: DATA_VALID_RX is low at edge M → after edge M, DONE=1 and RESOLVED_MAC=SHA, with BUSY=0 in the same cycle.
- Match and timeout at the same edge: the match wins (DONE, no retry).
- FAIL pulses together with BUSY falling. RESOLVED_MAC is unchanged on FAIL.
- DONE and FAIL are never high together, and neither is asserted for more than one cycle.

## Test plan
- Basic resolve:
  - Stimulus: MY_MAC=00_02_23_01_02_03, MY_IPV4=C0_A8_01_02; START with target C0_A8_01_01; ACK held high. After TX, feed a reply: dest MY_MAC, SHA 00_01_42_00_5F_68, SPA C0_A8_01_01, TPA C0_A8_01_02, OP 0002.
  - Required: the 42 TX bytes equal the frame layout exactly; one DONE pulse; RESOLVED_MAC=00_01_42_00_5F_68.
- ACK backpressure: ACK high only every third cycle → every byte is held until acked; DATA_VALID_TX stays high for 124 cycles with no gaps; byte sequence is unchanged.
- Timeout then retry: TIMEOUT_CYCLES=1000, no reply to the first request, then a valid reply after the second → exactly two TX frames; the second starts exactly 1000 cycles after the first's last ack; then DONE.
- Exhaustion: MAX_TRIES=3, never reply → three frames, then one FAIL pulse; BUSY=0 afterwards; RESOLVED_MAC retains its prior value.
- Rejection: in WAIT, feed these frames, each followed by WAIT continuing:
  - a reply with SPA C0_A8_01_07
  - an OP 0001 request
  - a 30-byte runt
  - a frame already in progress when WAIT is entered, then the valid reply
  - Required: no DONE for the first four; DONE on the valid reply.
- Reset and ignore: START pulsed again while BUSY is ignored. ARESET asserted at TX byte 20 → DATA_VALID_TX=0 immediately; all outputs return to reset values; a subsequent START completes normally.

Source files
------------

// File: rtl/arp_request_if.sv
// Byte-wide MAC-side bundle for the ARP request initiator: own addresses,
// request strobe, RX/TX byte streams and the resolve/fail status.
interface arp_request_if;
    logic [47:0] my_mac;
    logic [31:0] my_ipv4;
    logic        start;
    logic [31:0] target_ipv4;
    logic        data_valid_rx;
    logic [7:0]  data_rx;
    logic        data_ack_tx;
    logic        data_valid_tx;
    logic [7:0]  data_tx;
    logic        busy;
    logic        done;
    logic        fail;
    logic [47:0] resolved_mac;

    // Seen from the ARP block.
    modport slave (
        input  my_mac, my_ipv4, start, target_ipv4,
        input  data_valid_rx, data_rx, data_ack_tx,
        output data_valid_tx, data_tx, busy, done, fail, resolved_mac
    );

    // Seen from the MAC / host side.
    modport master (
        output my_mac, my_ipv4, start, target_ipv4,
        output data_valid_rx, data_rx, data_ack_tx,
        input  data_valid_tx, data_tx, busy, done, fail, resolved_mac
    );
endinterface

// File: rtl/arp_request.sv
// ARP initiator: sends a broadcast ARP request for a latched IPv4 target,
// waits for the matching reply, retries on timeout, reports DONE or FAIL.
//
// state  | meaning
// S_IDLE | waiting for START, outputs quiet
// S_TX   | streaming the 42-byte request, one byte per ack
// S_WAIT | parsing RX frames for the reply, timeout counter running
module arp_request #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_TRIES      = 3
) (
    input  logic          i_clk,
    input  logic          i_areset,
    arp_request_if.slave  io_arp
);
    typedef enum logic [1:0] {S_IDLE, S_TX, S_WAIT} state_t;

    localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  TRIES_LAST = 4'(MAX_TRIES);
    localparam logic [5:0]  LAST_IDX   = 6'd41;
    localparam logic [5:0]  HDR_BYTES  = 6'd42;

    state_t      r_state;
    logic [5:0]  r_tx_idx;
    logic [3:0]  r_tries;
    logic [23:0] r_tmo_cnt;
    logic [31:0] r_target;
    logic        r_data_valid_tx;
    logic [7:0]  r_data_tx;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic [47:0] r_resolved_mac;

    logic [5:0]  r_rx_cnt;
    logic        r_rx_ok;
    logic        r_rx_elig;
    logic [47:0] r_sha;

    // Whole request frame, byte 0 in the top bits.
    logic [335:0] w_tx_frame;
    logic [5:0]   w_tx_nidx;
    logic [8:0]   w_tx_shamt;
    logic [335:0] w_tx_shifted;
    logic [7:0]   w_tx_next;

    assign w_tx_frame = {48'hFFFF_FFFF_FFFF, io_arp.my_mac,
                         16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                         io_arp.my_mac, io_arp.my_ipv4, 48'h0, r_target};
    assign w_tx_nidx    = r_tx_idx + 6'd1;
    assign w_tx_shamt   = {LAST_IDX - w_tx_nidx, 3'b000};
    assign w_tx_shifted = w_tx_frame >> w_tx_shamt;
    assign w_tx_next    = w_tx_shifted[7:0];

    // Expected reply and care mask; src MAC, SHA and THA are don't-care.
    logic [335:0] w_rx_exp;
    logic [335:0] w_rx_mask;
    logic [8:0]   w_rx_shamt;
    logic [335:0] w_rx_exp_sh;
    logic [335:0] w_rx_mask_sh;
    logic         w_rx_byte_ok;
    logic         w_rx_first;
    logic         w_rx_end;
    logic         w_match;

    assign w_rx_exp  = {io_arp.my_mac, 48'h0,
                        16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                        48'h0, r_target, 48'h0, io_arp.my_ipv4};
    assign w_rx_mask = {{48{1'b1}}, 48'h0, {80{1'b1}}, 48'h0,
                        {32{1'b1}}, 48'h0, {32{1'b1}}};
    assign w_rx_shamt   = {LAST_IDX - r_rx_cnt, 3'b000};
    assign w_rx_exp_sh  = w_rx_exp >> w_rx_shamt;
    assign w_rx_mask_sh = w_rx_mask >> w_rx_shamt;
    assign w_rx_byte_ok = (r_rx_cnt > LAST_IDX) ||
                          (((io_arp.data_rx ^ w_rx_exp_sh[7:0]) & w_rx_mask_sh[7:0]) == 8'h00);
    assign w_rx_first   = io_arp.data_valid_rx && (r_rx_cnt == 6'd0);
    assign w_rx_end     = !io_arp.data_valid_rx && (r_rx_cnt != 6'd0);
    assign w_match      = (r_state == S_WAIT) && w_rx_end && r_rx_elig &&
                          r_rx_ok && (r_rx_cnt >= HDR_BYTES);

    // RX parser: byte count, accumulated field match, SHA shadow, eligibility.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_rx_cnt  <= 6'd0;
            r_rx_ok   <= 1'b0;
            r_rx_elig <= 1'b0;
            r_sha     <= 48'h0;
        end else begin
            if (io_arp.data_valid_rx) begin
                if (r_rx_cnt != 6'd63)
                    r_rx_cnt <= r_rx_cnt + 6'd1;
                r_rx_ok <= (w_rx_first ? 1'b1 : r_rx_ok) & w_rx_byte_ok;
                if (r_rx_cnt >= 6'd22 && r_rx_cnt <= 6'd27)
                    r_sha <= {r_sha[39:0], io_arp.data_rx};
            end else begin
                r_rx_cnt <= 6'd0;
            end
            // A frame is only eligible if its first byte lands while waiting.
            if (r_state != S_WAIT)
                r_rx_elig <= 1'b0;
            else if (w_rx_first)
                r_rx_elig <= 1'b1;
            else if (!io_arp.data_valid_rx)
                r_rx_elig <= 1'b0;
        end
    end

    // Main sequencer: request transmit, reply wait, timeout and retry.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_state         <= S_IDLE;
            r_tx_idx        <= 6'd0;
            r_tries         <= 4'd0;
            r_tmo_cnt       <= 24'd0;
            r_target        <= 32'h0;
            r_data_valid_tx <= 1'b0;
            r_data_tx       <= 8'h00;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_fail          <= 1'b0;
            r_resolved_mac  <= 48'h0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_arp.start) begin
                        r_target        <= io_arp.target_ipv4;
                        r_tries         <= 4'd1;
                        r_tx_idx        <= 6'd0;
                        r_data_tx       <= 8'hFF;
                        r_data_valid_tx <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= S_TX;
                    end
                end
                S_TX: begin
                    if (io_arp.data_ack_tx) begin
                        if (r_tx_idx == LAST_IDX) begin
                            r_data_valid_tx <= 1'b0;
                            r_data_tx       <= 8'h00;
                            r_tmo_cnt       <= 24'd0;
                            r_state         <= S_WAIT;
                        end else begin
                            r_tx_idx  <= w_tx_nidx;
                            r_data_tx <= w_tx_next;
                        end
                    end
                end
                S_WAIT: begin
                    // A reply completing on the timeout edge still wins.
                    if (w_match) begin
                        r_done         <= 1'b1;
                        r_resolved_mac <= r_sha;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        if (r_tries < TRIES_LAST) begin
                            r_tries         <= r_tries + 4'd1;
                            r_tx_idx        <= 6'd0;
                            r_data_tx       <= 8'hFF;
                            r_data_valid_tx <= 1'b1;
                            r_state         <= S_TX;
                        end else begin
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 24'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_arp.data_valid_tx = r_data_valid_tx;
    assign io_arp.data_tx       = r_data_tx;
    assign io_arp.busy          = r_busy;
    assign io_arp.done          = r_done;
    assign io_arp.fail          = r_fail;
    assign io_arp.resolved_mac  = r_resolved_mac;
endmodule

// File: tb/tb_arp_request.sv
// Directed bench for arp_request: resolve, backpressure, retry, exhaustion,
// rejection of non-matching frames and reset mid-frame.
module tb_arp_request;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arp_request_if u_if();

    arp_request #(.TIMEOUT_CYCLES(1000), .MAX_TRIES(3)) u_dut (
        .i_clk    (clk),
        .i_areset (rst),
        .io_arp   (u_if)
    );

    localparam logic [47:0]  MAC = 48'h000223010203;
    localparam logic [31:0]  IP  = 32'hC0A80102;
    localparam logic [31:0]  TGT = 32'hC0A80101;
    localparam logic [47:0]  SHA = 48'h000142005F68;
    localparam logic [335:0] EXP_REQ = 336'hFFFFFFFFFFFF_000223010203_0806_0001_0800_06_04_0001_000223010203_C0A80102_000000000000_C0A80101;
    localparam logic [335:0] GOOD_REP = 336'h000223010203_000142005F68_0806_0001_0800_06_04_0002_000142005F68_C0A80101_000223010203_C0A80102;
    localparam logic [335:0] BAD_SPA = 336'h000223010203_000142005F68_0806_0001_0800_06_04_0002_000142005F68_C0A80107_000223010203_C0A80102;
    localparam logic [335:0] OP_REQ = 336'h000223010203_000142005F68_0806_0001_0800_06_04_0001_000142005F68_C0A80101_000000000000_C0A80102;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, fail_cnt = 0, overlap_cnt = 0, long_cnt = 0;
    logic done_q = 1'b0, fail_q = 1'b0;
    logic [7:0] tx_got [42];
    int tx_cycles, tx_bytes, tx_hold_err;

    task automatic chk(input string tag, input logic [335:0] obs, input logic [335:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (u_if.done) done_cnt++;
        if (u_if.fail) fail_cnt++;
        if (u_if.done && u_if.fail) overlap_cnt++;
        if ((u_if.done && done_q) || (u_if.fail && fail_q)) long_cnt++;
        done_q = u_if.done;
        fail_q = u_if.fail;
    endtask

    task automatic collect_tx(input int period);
        int n, k, guard;
        logic [7:0] prev;
        logic ack_prev;
        n = 0; k = 0; guard = 0; tx_hold_err = 0; prev = 8'h00; ack_prev = 1'b1;
        while (!u_if.data_valid_tx && guard < 3000) begin tick(); guard++; end
        while (u_if.data_valid_tx && n < 400) begin
            if (!ack_prev && u_if.data_tx !== prev) tx_hold_err++;
            u_if.data_ack_tx = ((n % period) == 0);
            if (u_if.data_ack_tx) begin
                if (k < 42) tx_got[k] = u_if.data_tx;
                k++;
            end
            prev = u_if.data_tx;
            ack_prev = u_if.data_ack_tx;
            n++;
            tick();
        end
        u_if.data_ack_tx = 1'b0;
        tx_cycles = n;
        tx_bytes = k;
    endtask

    task automatic pack_tx(output logic [335:0] v);
        v = '0;
        for (int i = 0; i < 42; i++) v = {v[327:0], tx_got[i]};
    endtask

    task automatic send_rx(input logic [335:0] f, input int nbytes);
        logic [335:0] s;
        s = f;
        for (int i = 0; i < nbytes; i++) begin
            u_if.data_valid_rx = 1'b1;
            u_if.data_rx = (i < 42) ? s[335:328] : 8'h00;
            s = s << 8;
            tick();
        end
        u_if.data_valid_rx = 1'b0;
        u_if.data_rx = 8'h00;
    endtask

    initial begin
        logic [335:0] got;
        int dc, fc, gap, frames, guard;
        logic prev_v, busy_at_fail, seen_fail;

        u_if.my_mac = MAC;
        u_if.my_ipv4 = IP;
        u_if.start = 1'b0;
        u_if.target_ipv4 = TGT;
        u_if.data_valid_rx = 1'b0;
        u_if.data_rx = 8'h00;
        u_if.data_ack_tx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();

        chk("rst_valid_tx", u_if.data_valid_tx, 1'b0);
        chk("rst_data_tx", u_if.data_tx, 8'h00);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_done", u_if.done, 1'b0);
        chk("rst_fail", u_if.fail, 1'b0);
        chk("rst_resolved", u_if.resolved_mac, 48'h0);

        // basic resolve, ack high
        u_if.data_ack_tx = 1'b1;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        chk("start_busy", u_if.busy, 1'b1);
        chk("start_valid", u_if.data_valid_tx, 1'b1);
        chk("start_byte0", u_if.data_tx, 8'hFF);
        collect_tx(1);
        pack_tx(got);
        chk("basic_frame", got, EXP_REQ);
        chk("basic_cycles", tx_cycles, 42);
        chk("basic_bytes", tx_bytes, 42);
        chk("wait_busy", u_if.busy, 1'b1);
        dc = done_cnt;
        send_rx(GOOD_REP, 46);
        tick();
        chk("basic_done", u_if.done, 1'b1);
        chk("basic_busy_low", u_if.busy, 1'b0);
        chk("basic_resolved", u_if.resolved_mac, SHA);
        tick();
        chk("basic_done_low", u_if.done, 1'b0);
        chk("basic_done_count", done_cnt - dc, 1);

        // backpressure, then START ignored while waiting
        u_if.target_ipv4 = TGT;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        u_if.target_ipv4 = 32'hC0A80109;
        collect_tx(3);
        pack_tx(got);
        chk("bp_frame", got, EXP_REQ);
        chk("bp_cycles", tx_cycles, 124);
        chk("bp_hold", tx_hold_err, 0);
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        repeat (3) tick();
        chk("ignore_start_tx", u_if.data_valid_tx, 1'b0);
        chk("ignore_start_busy", u_if.busy, 1'b1);
        send_rx(GOOD_REP, 42);
        tick();
        chk("bp_done", u_if.done, 1'b1);
        u_if.target_ipv4 = TGT;

        // timeout then retry
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        collect_tx(1);
        pack_tx(got);
        chk("retry_frame1", got, EXP_REQ);
        gap = 0;
        while (!u_if.data_valid_tx && gap < 2000) begin tick(); gap++; end
        chk("retry_gap", gap, 1000);
        collect_tx(1);
        pack_tx(got);
        chk("retry_frame2", got, EXP_REQ);
        send_rx(GOOD_REP, 42);
        tick();
        chk("retry_done", u_if.done, 1'b1);
        repeat (5) tick();
        chk("retry_no_third", u_if.data_valid_tx, 1'b0);

        // rejection of non-matching frames
        u_if.data_ack_tx = 1'b1;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        repeat (29) tick();
        dc = done_cnt;
        send_rx(GOOD_REP, 46);
        tick();
        chk("rej_inprog_busy", u_if.busy, 1'b1);
        send_rx(BAD_SPA, 42);
        tick();
        send_rx(OP_REQ, 42);
        tick();
        send_rx(GOOD_REP, 30);
        tick();
        chk("rej_no_done", done_cnt - dc, 0);
        chk("rej_busy", u_if.busy, 1'b1);
        chk("rej_no_retry", u_if.data_valid_tx, 1'b0);
        send_rx(GOOD_REP, 42);
        tick();
        chk("rej_final_done", u_if.done, 1'b1);
        u_if.data_ack_tx = 1'b0;

        // exhaustion
        u_if.data_ack_tx = 1'b1;
        fc = fail_cnt;
        dc = done_cnt;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        frames = u_if.data_valid_tx ? 1 : 0;
        prev_v = u_if.data_valid_tx;
        seen_fail = 1'b0;
        busy_at_fail = 1'b1;
        guard = 0;
        while (!seen_fail && guard < 5000) begin
            tick();
            guard++;
            if (u_if.data_valid_tx && !prev_v) frames++;
            prev_v = u_if.data_valid_tx;
            if (u_if.fail) begin
                seen_fail = 1'b1;
                busy_at_fail = u_if.busy;
            end
        end
        repeat (3) tick();
        chk("exh_seen_fail", seen_fail, 1'b1);
        chk("exh_frames", frames, 3);
        chk("exh_fail_count", fail_cnt - fc, 1);
        chk("exh_busy_at_fail", busy_at_fail, 1'b0);
        chk("exh_busy_after", u_if.busy, 1'b0);
        chk("exh_no_done", done_cnt - dc, 0);
        chk("exh_resolved_kept", u_if.resolved_mac, SHA);

        // reset mid-frame
        u_if.data_ack_tx = 1'b1;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        repeat (19) tick();
        chk("mid_byte19", u_if.data_tx, 8'h04);
        tick();
        chk("mid_valid", u_if.data_valid_tx, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_tx", u_if.data_valid_tx, 1'b0);
        chk("arst_data_tx", u_if.data_tx, 8'h00);
        chk("arst_busy", u_if.busy, 1'b0);
        chk("arst_resolved", u_if.resolved_mac, 48'h0);
        dc = done_cnt;
        fc = fail_cnt;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("arst_no_pulse", (done_cnt - dc) + (fail_cnt - fc), 0);
        chk("arst_idle", u_if.data_valid_tx, 1'b0);
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        collect_tx(1);
        pack_tx(got);
        chk("post_rst_frame", got, EXP_REQ);
        send_rx(GOOD_REP, 42);
        tick();
        chk("post_rst_done", u_if.done, 1'b1);
        chk("post_rst_resolved", u_if.resolved_mac, SHA);

        chk("done_fail_overlap", overlap_cnt, 0);
        chk("pulse_width", long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
